// File: rtl/binact_pool.sv
// Binarise signed conv sums against a folded-BN threshold, then 2x2/stride-2 max-pool
// (an OR on binary data). Two layer geometries share one line buffer sized for the wider.
module binact_pool #(
    parameter int DW   = 5,
    parameter int W_L0 = 24,
    parameter int H_L0 = 24,
    parameter int W_L1 = 8,
    parameter int H_L1 = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 state,
    input  logic                 thr_en,
    input  logic signed [DW-1:0] thr,
    input  logic signed [DW-1:0] din,
    input  logic                 ivalid,
    input  logic                 idone,
    output logic                 dout,
    output logic                 ovalid,
    output logic                 done,
    output logic                 err
);

    localparam int WMAX = (W_L0 > W_L1) ? W_L0 : W_L1;
    localparam int HMAX = (H_L0 > H_L1) ? H_L0 : H_L1;
    localparam int CW   = $clog2(WMAX);
    localparam int RW   = $clog2(HMAX);
    localparam int LB   = WMAX / 2;

    logic signed [DW-1:0] r_thr;
    logic                 r_layer;
    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic                 r_pair;
    logic [LB-1:0]        r_line;
    logic                 r_dout_p1;
    logic                 r_vld_p1;
    logic                 r_done_p1;
    logic                 r_err;

    logic                 w_layer;
    logic [CW-1:0]        w_col;
    logic [RW-1:0]        w_row;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_bit;
    logic                 w_frame_end;
    logic                 w_abort;
    logic                 w_lb_rd;

    // A start in the same cycle as ivalid makes that sample pixel (0,0) of the new layer.
    always_comb begin
        w_layer     = start ? state : r_layer;
        w_col       = start ? '0 : r_col;
        w_row       = start ? '0 : r_row;
        w_col_last  = (w_col == (w_layer ? CW'(W_L1 - 1) : CW'(W_L0 - 1)));
        w_row_last  = (w_row == (w_layer ? RW'(H_L1 - 1) : RW'(H_L0 - 1)));
        w_bit       = (din >= r_thr);
        w_frame_end = ivalid && w_col_last && w_row_last;
        w_abort     = !start && idone && ((r_col != '0) || (r_row != '0)) && !w_frame_end;
        w_lb_rd     = r_line[w_col[CW-1:1]];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_thr     <= '0;
            r_layer   <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
            r_pair    <= 1'b0;
            r_line    <= '0;
            r_dout_p1 <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_done_p1 <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_vld_p1  <= 1'b0;
            r_done_p1 <= 1'b0;
            if (thr_en) begin
                r_thr <= thr;
            end
            if (start) begin
                r_layer <= state;
                r_col   <= '0;
                r_row   <= '0;
                r_pair  <= 1'b0;
                r_line  <= '0;
                r_err   <= 1'b0;
            end
            if (w_abort) begin
                r_err <= 1'b1;
                r_col <= '0;
                r_row <= '0;
            end else if (ivalid) begin
                // stage p0 -> p1: pooled pixel registered on the odd/odd sample
                if (!w_col[0]) begin
                    r_pair <= w_bit;
                end else if (!w_row[0]) begin
                    r_line[w_col[CW-1:1]] <= r_pair | w_bit;
                end else begin
                    r_dout_p1 <= w_lb_rd | r_pair | w_bit;
                    r_vld_p1  <= 1'b1;
                    r_done_p1 <= w_frame_end;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                end
            end
        end
    end

    assign dout   = r_dout_p1;
    assign ovalid = r_vld_p1;
    assign done   = r_done_p1;
    assign err    = r_err;

endmodule
